// File: rtl/conv2d_zout.sv
// conv2d_zout: output post-processing stage of the conv2d engine.
// Each output pixel goes through four stages: accumulate the partial sums,
// add the bias, apply a rounding right shift, then ReLU/saturate and emit.
//   clk, rst          clock, synchronous active-high reset
//   param_*           layer parameters, loaded on a rising edge of param_ena
//   psum_ena, psum    partial-sum input stream
//   pxl_ena_z, pxl_z  output pixel stream (one-cycle strobe per pixel)
//   flag_calc_over    sticky layer-complete flag
module conv2d_zout #(
   parameter int SW = 40,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          param_ena,
   input  logic [7:0]    param_nsum,
   input  logic [DW-1:0] param_bias,
   input  logic [4:0]    param_shift,
   input  logic          param_relu,
   input  logic [17:0]   param_length_out,
   input  logic          psum_ena,
   input  logic [DW-1:0] psum,
   output logic          pxl_ena_z,
   output logic [DW-1:0] pxl_z,
   output logic          flag_calc_over
);
   localparam logic signed [SW+1:0] MAX = {{(SW+3-DW){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [SW+1:0] MIN = {{(SW+3-DW){1'b1}}, {(DW-1){1'b0}}};
   logic                   param_ena_d, ld, v1, v2, v3, emit;
   logic [7:0]             nsum, cnt_sum;
   logic [DW-1:0]          bias, sat;
   logic [4:0]             shift;
   logic                   relu;
   logic [17:0]            len, cnt_pix;
   logic signed [SW-1:0]   acc, psx;
   logic signed [SW:0]     b;
   logic signed [SW+1:0]   bx, rnd, sh, r, vr;
   assign ld = param_ena & ~param_ena_d;
   assign psx = {{(SW-DW){psum[DW-1]}}, psum};
   assign emit = v3 && (cnt_pix < len);
   // Shift at SW+2 bits so the rounding increment can never overflow.
   always_comb begin
      bx = {b[SW], b};
      rnd = (shift == 5'd0) ? '0 : ((SW+2)'(1) << (shift - 5'd1));
      sh = (bx + rnd) >>> shift;
      vr = (relu && r[SW+1]) ? '0 : r;
      sat = (vr > MAX) ? MAX[DW-1:0] : (vr < MIN) ? MIN[DW-1:0] : vr[DW-1:0];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         param_ena_d <= 1'b0;
         nsum <= '0;
         bias <= '0;
         shift <= '0;
         relu <= 1'b0;
         len <= '0;
         cnt_sum <= '0;
         cnt_pix <= '0;
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
         pxl_ena_z <= 1'b0;
         pxl_z <= '0;
         flag_calc_over <= 1'b0;
      end else begin
         param_ena_d <= param_ena;
         b <= {acc[SW-1], acc} + {{(SW+1-DW){bias[DW-1]}}, bias};
         r <= sh;
         if (ld) begin
            nsum <= param_nsum;
            bias <= param_bias;
            shift <= param_shift;
            relu <= param_relu;
            len <= param_length_out;
            cnt_sum <= '0;
            cnt_pix <= '0;
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            pxl_ena_z <= 1'b0;
            flag_calc_over <= 1'b0;
         end else begin
            v1 <= psum_ena && (cnt_sum == nsum);
            v2 <= v1;
            v3 <= v2;
            if (psum_ena) begin
               acc <= (cnt_sum == 8'd0) ? psx : acc + psx;
               cnt_sum <= (cnt_sum == nsum) ? 8'd0 : cnt_sum + 8'd1;
            end
            pxl_ena_z <= emit;
            if (emit) begin
               pxl_z <= sat;
               cnt_pix <= cnt_pix + 18'd1;
            end
            flag_calc_over <= flag_calc_over | (cnt_pix == len);
         end
      end
   end
endmodule

// File: doc/conv2d_zout.md
Name: conv2d_zout

Overview:
Output post-processing stage of the conv2d engine, directly upstream of the output write-memory stage. It accumulates a programmable number of partial sums per output pixel, then applies bias, a rounding arithmetic right shift, optional ReLU and signed 32-bit saturation. Results go out as the pxl_ena_z/pxl_z stream. It counts emitted pixels against the layer length and raises flag_calc_over when the layer is complete.

Parameters:
SW, 40, accumulator width in bits (signed); must be ≥ 40.
DW, 32, psum / bias / output pixel width in bits (signed).

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
param_ena  input  1  layer-parameter valid; its rising edge (registered compare) loads all param_* inputs.
param_nsum  input  8  partial sums per pixel minus one (0 → 1 psum, 255 → 256 psums).
param_bias  input  DW  signed bias added per pixel.
param_shift  input  5  arithmetic right-shift amount (0..31).
param_relu  input  1  1 = clamp negative results to 0.
param_length_out  input  18  pixels in the layer.
psum_ena  input  1  partial-sum valid strobe.
psum  input  DW  signed partial sum.
pxl_ena_z  output  1  output pixel valid, one-cycle strobe per pixel.
pxl_z  output  DW  output pixel, signed.
flag_calc_over  output  1  layer complete (sticky).

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values: pxl_ena_z=0, pxl_z=0, flag_calc_over=0. All pipeline valid bits, cnt_sum and cnt_pix are 0. Latched params are 0.
- Load (ld) = param_ena & ~param_ena_d.
  - On ld: latch params; clear cnt_sum, cnt_pix and flag_calc_over; clear all in-flight pipeline valid bits, so partial pixels are dropped.
  - psum_ena in the ld cycle is ignored.
  - rst mid-layer behaves the same as ld, and additionally zeroes all params.
- S0, accumulate:
  - On psum_ena, sign-extend psum to SW.
  - If cnt_sum==0: acc <= psum. Otherwise: acc <= acc + psum.
  - If cnt_sum==nsum: cnt_sum <= 0 and v1 <= 1. Otherwise: cnt_sum++ and v1 <= 0.
  - No psum_ena: acc and cnt_sum hold, v1 <= 0.
  - acc wraps at SW bits; no overflow detection.
- S1, bias: b <= acc + sext(bias) at SW+1 bits; v2 <= v1.
- S2, shift:
  - shift=0: r <= b.
  - shift>0: r <= (b + 2^(shift-1)) >>> shift, i.e. round half toward +inf.
  - v3 <= v2.
- S3, output:
  - If relu and r<0: value = 0.
  - Saturate value to [-2^31, 2^31-1].
  - pxl_z <= value; pxl_ena_z <= v3 & (cnt_pix < length_out); cnt_pix increments on each emitted pixel.
  - pxl_z holds its last value when pxl_ena_z=0.
- Latency: the final psum of a pixel sampled at cycle T gives pxl_ena_z high at T+4. Full throughput: one psum per cycle; nsum=0 gives one pixel per cycle.
- Completion:
  - flag_calc_over rises the cycle after the pixel that makes cnt_pix == length_out. It stays high until ld or rst.
  - Results with cnt_pix == length_out are discarded: no strobe, cnt_pix saturates.
  - length_out=0: flag_calc_over rises the cycle after ld; no pixels are ever emitted.
- No backpressure: the downstream stage always accepts pxl_ena_z.

Test Plan:
1. Basic path: nsum=3, bias=28, shift=2, relu=0, length_out=1; psums 10,20,30,40 on consecutive cycles → pxl_z=32, pxl_ena_z exactly 4 cycles after psum 40; flag_calc_over=1 the next cycle.
2. Rounding and sign: nsum=0, bias=0, shift=2, relu=0; psums 6, -6, -7 → pxl_z = 2, -1, -2, emitted back-to-back.
3. ReLU and saturation:
   - nsum=0, shift=0, relu=1; psum -100 → 0, psum 5 → 5.
   - nsum=1, relu=0, bias=0x7FFFFFFF; psums 0x7FFFFFFF, 0x7FFFFFFF → 0x7FFFFFFF.
   - nsum=0, bias=0x80000000, psum=0x80000000 → 0x80000000.
4. Length limit: nsum=0, length_out=3; 5 psums → exactly 3 strobes; flag_calc_over rises after the 3rd and stays high; the 4th and 5th are dropped.
5. Reload mid-pixel: nsum=3; after 2 psums, toggle param_ena 0→1 with new nsum=0; then psum 7 → single pixel 7 (old partial discarded); flag_calc_over cleared by ld.
6. Reset mid-pipeline: assert rst one cycle after a final psum → no pxl_ena_z; all outputs 0 the cycle after rst.
